// File: rtl/tdm_demux_1_2.sv
// tdm_demux_1_2: frame-locked 1:2 TDM deserializer with framing-error tracking
module tdm_demux_1_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             frame,
  input  logic             en,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid0,
  output logic             valid1,
  output logic             s0,
  output logic             locked,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SLOT0, SLOT1, CHECK} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] shift;
  logic done0, done1, err;
  assign s0 = state == SLOT1;
  assign locked = state != IDLE;
  // state and in-slot bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // next state; an early frame marker outranks word completion
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    done0 = 1'b0;
    done1 = 1'b0;
    err = 1'b0;
    if (en)
      case (state)
        IDLE: if (frame) begin
          state_nx = SLOT0;
          cnt_nx = CW'(1);
        end
        SLOT0, SLOT1: if (frame && cnt != '0) begin
          err = 1'b1;
          state_nx = SLOT0;
          cnt_nx = CW'(1);
        end else if (cnt == LAST) begin
          done0 = state == SLOT0;
          done1 = state == SLOT1;
          cnt_nx = '0;
          state_nx = state == SLOT0 ? SLOT1 : CHECK;
        end else
          cnt_nx = cnt + 1'b1;
        default: if (frame) begin
          state_nx = SLOT0;
          cnt_nx = CW'(1);
        end else begin
          err = 1'b1;
          state_nx = IDLE;
          cnt_nx = '0;
        end
      endcase
  end
  // shift register, word outputs, strobes and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      out0 <= '0;
      out1 <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      valid0 <= done0;
      valid1 <= done1;
      frame_err <= err;
      if (en) shift <= {shift[WIDTH-2:0], din};
      if (done0) out0 <= {shift[WIDTH-2:0], din};
      if (done1) out1 <= {shift[WIDTH-2:0], din};
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: doc/tdm_demux_1_2.md
# tdm_demux_1_2

Receive-side time-division demultiplexer that splits one serial 1-bit line into two parallel channels. A 2:1 mux upstream interleaves channel 0 and channel 1 onto the wire. This block delineates each frame from a frame marker and deserializes each time slot into its own output register with a one-cycle valid strobe. It also tracks framing errors.

## Interface
Parameters:
- WIDTH, 8, bits per time slot; legal values are 2 or greater; frame length is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all sampling happens on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data, MSB first within each slot.
- frame  input  1  high together with the first bit (slot 0 MSB) of every frame.
- en  input  1  bit-enable; din and frame are sampled only on edges where en=1.
- out0  output  WIDTH  last complete channel-0 word.
- out1  output  WIDTH  last complete channel-1 word.
- valid0  output  1  one-cycle pulse when out0 updates.
- valid1  output  1  one-cycle pulse when out1 updates.
- s0  output  1  slot selector; 1 when the next enabled bit belongs to slot 1.
- locked  output  1  high in states SLOT0, SLOT1 and CHECK.
- frame_err  output  1  one-cycle pulse on each framing error.
- err_cnt  output  8  count of framing errors; saturates at 255.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE and the bit counter resets to 0.
- The FSM has four states: IDLE, SLOT0, SLOT1, CHECK. A counter `cnt` (clog2(WIDTH) bits) counts the bits already taken in the current slot.
- An edge with en=0 changes no state, counter or shift register, and ignores frame. It still clears valid0, valid1 and frame_err.
- IDLE:
  - On an enabled bit with frame=1, load din as bit 0 and go to SLOT0.
  - On an enabled bit with frame=0, stay in IDLE. This is not an error.
- SLOT0:
  - Shift din into the shift register.
  - On the WIDTH-th bit, load out0 with {shift[WIDTH-2:0], din}, pulse valid0, clear cnt and go to SLOT1.
- SLOT1:
  - Same as SLOT0, but updates out1 and pulses valid1, then goes to CHECK.
- CHECK:
  - On an enabled bit with frame=1, start a new frame: this bit is slot 0 bit 0, go to SLOT0.
  - On an enabled bit with frame=0, pulse frame_err, increment err_cnt and go to IDLE.
- Early frame: an enabled bit with frame=1 in SLOT0 or SLOT1 when cnt is not 0 is an error.
  - Pulse frame_err and increment err_cnt.
  - Discard the partial word; no valid pulse is issued.
  - Restart in SLOT0 with this bit taken as bit 0 (cnt=1).
- frame=1 together with the last bit of a slot counts as an early frame. The early-frame rule takes priority over completing the word.
- err_cnt increments by 1 per error and holds at 255.
- s0 is 1 exactly in state SLOT1.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- out0 and valid0 change on the same edge that samples the last bit of slot 0. valid0 is high for exactly one clock after that edge. out1 and valid1 behave the same way for slot 1.
- With en held at 1, frames are back-to-back every 2*WIDTH cycles with no gap bits. valid0 and valid1 are WIDTH cycles apart.
- out0 and out1 hold their values until the next completed word.
- Asserting rst_n low clears all state and outputs immediately, including mid-frame. A partial word is lost.
- After rst_n deassertion, the first enabled bit is accepted on the next rising edge.

## Test plan
All scenarios use WIDTH=4.
- Single frame, en=1: frame pulses with bit 1, stream 1,0,1,0,0,1,1,0, then a frame bit.
  - out0=4'hA with valid0 pulsed after edge 4.
  - out1=4'h6 with valid1 pulsed after edge 8.
  - s0 is 1 during edges 5-8.
  - locked=1 from edge 1.
- Three back-to-back frames with words A/6, 3/C, F/0.
  - Six valid pulses, each exactly 4 cycles apart.
  - frame_err stays 0 and err_cnt stays 0.
- Early frame: frame re-asserted on the 3rd bit of slot 1.
  - frame_err pulses once and err_cnt=1.
  - No valid1 pulse; out1 keeps its old value.
  - The following 4 bits 1,1,0,0 give out0=4'hC.
- Missing frame: after slot 1, an enabled bit arrives with frame=0.
  - frame_err pulses, err_cnt increments, locked drops to 0, state is IDLE.
  - The next frame=1 relocks.
- Stall and reset:
  - en=0 for 3 cycles after the 2nd bit of slot 0: out0 still equals 4'hA after the remaining 2 enabled bits.
  - rst_n low after the 6th bit: all outputs read 0 at once. A new frame then decodes correctly.
- Saturation: force 260 framing errors. err_cnt reads 255 and frame_err still pulses on every error.
